// File: rtl/b11_feeder.sv
// Feeds a downstream b11 stage from a 4-deep FIFO, spacing active-low strobes GAP+1 cycles apart.
// Optional B11_FEED_SKIP_EN: accepted words 27..62 are discarded and counted in drop_cnt.
module b11_feeder #(
    parameter int unsigned GAP = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d_in,
    input  logic       d_valid,
    output logic       d_ready,
    output logic [5:0] x_in,
    output logic       stbi,
    output logic [2:0] fill,
    output logic [3:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [5:0]  x_next;
    logic        stbi_next;
    logic        load;
    logic [5:0]  mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic        push;
    logic        skip;
    logic        store;
    logic        pop;

    // Full blocks writes even when a pop lands on the same edge.
    assign d_ready = (fill != 3'd4);
    assign push    = d_valid && d_ready;

`ifdef B11_FEED_SKIP_EN
    assign skip = (d_in >= 6'd27) && (d_in <= 6'd62);
`else
    assign skip = 1'b0;
`endif

    assign store = push && !skip;
    assign pop   = load;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        x_next     = x_in;
        stbi_next  = stbi;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (fill != 3'd0) begin
                    load = 1'b1;
                end
            end
            STROBE: begin
                stbi_next  = 1'b1;
                cnt_next   = 4'(GAP - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    if (fill != 3'd0) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (load) begin
            x_next     = mem[rd_ptr];
            stbi_next  = 1'b0;
            state_next = STROBE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            x_in  <= '0;
            stbi  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            x_in  <= x_next;
            stbi  <= stbi_next;
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            mem[wr_ptr] <= d_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            drop_cnt <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fill <= 3'(fill + {2'b00, store} - {2'b00, pop});
            if (push && skip && (drop_cnt != 4'hF)) begin
                drop_cnt <= drop_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/b11_feeder.md
B11_FEEDER -- requirements
Module: b11_feeder

Interface
REQ-001 The module SHALL have a parameter GAP, default 8, giving the number of stbi-high cycles after each strobe; the legal range is 1..15.
REQ-002 clock  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 d_in  input  6  Upstream data word.
REQ-005 d_valid  input  1  Upstream word is valid.
REQ-006 d_ready  output  1  Feeder can accept a word; it SHALL equal !full.
REQ-007 x_in  output  6  Word presented to the downstream b11 stage.
REQ-008 stbi  output  1  Downstream strobe, active-low: 0 for one cycle releases the word, 1 holds.
REQ-009 fill  output  3  Current FIFO occupancy, 0..4.
REQ-010 drop_cnt  output  4  Saturating count of discarded words.

Function
REQ-011 The module SHALL contain a 4-entry, 6-bit FIFO that is written when d_valid && d_ready at a clock edge.
REQ-012 When full (fill==4), d_ready SHALL be 0 and d_in SHALL be ignored, even if a pop happens in the same cycle.
REQ-013 A simultaneous push and pop on a non-full FIFO SHALL leave fill unchanged and preserve word order.
REQ-014 The FSM SHALL have three states: IDLE, STROBE and WAIT.
REQ-015 In IDLE with fill>0, the next edge SHALL load x_in<=head word, pop the FIFO, drive stbi<=0 and go to STROBE.
REQ-016 In IDLE with fill==0, the state SHALL be held and stbi SHALL stay 1.
REQ-017 STROBE SHALL last exactly one cycle; the next edge SHALL set stbi<=1, load the gap counter with GAP-1 and go to WAIT.
REQ-018 In WAIT, the counter SHALL decrement each cycle.
REQ-019 At counter==0 in WAIT: if fill>0, the FSM SHALL go directly to STROBE with the same load/pop actions as IDLE; otherwise it SHALL go to IDLE.
REQ-020 Under backlog, consecutive strobes SHALL be exactly GAP+1 cycles apart: one stbi-low cycle followed by GAP stbi-high cycles.
REQ-021 Latency: a word written at edge t into an empty FIFO with the FSM in IDLE SHALL appear on x_in with stbi=0 after edge t+1.
REQ-022 x_in SHALL hold the last presented word until the next strobe and SHALL never change while stbi=1.
REQ-023 stbi SHALL never be 0 for two consecutive cycles.
REQ-024 fill SHALL be a registered count that is updated on push/pop edges.
REQ-025 drop_cnt SHALL saturate at 15 and SHALL never wrap.

Reset
REQ-026 While reset is asserted, asynchronously: x_in=0, stbi=1, fill=0, drop_cnt=0, FSM=IDLE, gap counter=0, FIFO pointers=0.
REQ-027 After reset, d_ready SHALL be 1.
REQ-028 Reset asserted during STROBE or WAIT SHALL immediately force stbi=1 and discard FIFO contents; no partial strobe SHALL follow its release.

Configuration
REQ-029 The macro B11_FEED_SKIP_EN SHALL control out-of-range word filtering.
REQ-030 With B11_FEED_SKIP_EN defined, an accepted word with value 27..62 SHALL be handshaken (d_ready honoured) but not stored, and drop_cnt SHALL increment; 0, 63 and 1..26 SHALL be stored.
REQ-031 Without B11_FEED_SKIP_EN, every accepted word SHALL be stored and drop_cnt SHALL remain 0.

Verification
REQ-032 Reset, then d_in=5 valid for 1 cycle -> one cycle later x_in=5, stbi=0 for exactly 1 cycle, then stbi=1 and fill=0.
REQ-033 GAP=8; write 3,4,5,6 back-to-back -> d_ready stays 1; strobes present 3,4,5,6 in order, spaced 9 cycles apart.
REQ-034 Fill to 4 while the FSM is in WAIT, then hold d_valid with d_in=9 -> d_ready=0 and 9 is not stored until a pop occurs; after the next strobe, 9 is accepted and presented last.
REQ-035 Assert reset mid-WAIT with fill=3 -> stbi=1, x_in=0, fill=0 immediately; no strobe after release until a new write.
REQ-036 B11_FEED_SKIP_EN defined; write 30,63,0,40 -> only 63 and 0 are presented, and drop_cnt=2; 20 writes of 50 -> drop_cnt=15.
REQ-037 B11_FEED_SKIP_EN undefined; write 30 -> 30 is presented and drop_cnt=0.
